mux_8_1_scan_ctrl: RTL and testbench

- Upstream controller for the 8:1 cascaded mux.
- Captures an 8-bit word and drives it onto the mux data inputs I0..I7.
- Steps the select lines S2..S0 through all eight channels and samples the mux output each cycle, converting the word into a registered serial bit stream.
- Checks every sampled bit against the captured word and raises a sticky error on mismatch, giving in-circuit self-test of the mux path.

---
 rtl/mux_8_1_scan_ctrl.sv | 113 +++++++++++
 tb/tb_mux_8_1_scan_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_8_1_scan_ctrl.sv
// Drives a captured byte onto an 8:1 mux and scans S2..S0 so the mux output becomes a serial stream.
// Load-to-first-SVALID 2 edges; HOLD stalls the scan, LOAD is ignored while BUSY; ERR is sticky on mismatch.
module mux_8_1_scan_ctrl #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       LOAD,
  input  logic [7:0] DIN,
  input  logic       HOLD,
  input  logic       MUX_OUT,
  output logic [7:0] I_BUS,
  output logic       S0,
  output logic       S1,
  output logic       S2,
  output logic       SOUT,
  output logic       SVALID,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  localparam int WIDTH_SEL = 3;
  localparam logic [WIDTH_SEL-1:0] SEL_START = MSB_FIRST ? 3'd7 : 3'd0;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t               state_q, state_d;
  logic [7:0]           ibus_q, ibus_d;
  logic [WIDTH_SEL-1:0] sel_q, sel_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 sout_q, sout_d;
  logic                 svalid_q, svalid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  always_comb begin
    state_d  = state_q;
    ibus_d   = ibus_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    sout_d   = sout_q;
    svalid_d = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (LOAD) begin
          ibus_d  = DIN;
          sel_d   = SEL_START;
          cnt_d   = 3'd0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (!HOLD) begin
          // The mux output reflects the select presented during this cycle.
          sout_d   = MUX_OUT;
          svalid_d = 1'b1;
          err_d    = err_q | (MUX_OUT != ibus_q[sel_q]);
          sel_d    = MSB_FIRST ? sel_q - 3'd1 : sel_q + 3'd1;
          cnt_d    = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            sel_d   = SEL_START;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      ibus_q   <= 8'd0;
      sel_q    <= '0;
      cnt_q    <= 3'd0;
      sout_q   <= 1'b0;
      svalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ibus_q   <= ibus_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      sout_q   <= sout_d;
      svalid_q <= svalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign I_BUS  = ibus_q;
  assign S0     = sel_q[0];
  assign S1     = sel_q[1];
  assign S2     = sel_q[2];
  assign SOUT   = sout_q;
  assign SVALID = svalid_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign ERR    = err_q;

endmodule

// File: tb/tb_mux_8_1_scan_ctrl.sv
// Bench for mux_8_1_scan_ctrl: one LSB-first and one MSB-first instance share stimulus, each feeding its own mux model.
// Expected serial streams are queued at LOAD acceptance and popped by a monitor on every SVALID.
module tb_mux_8_1_scan_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       LOAD = 1'b0;
  logic       HOLD = 1'b0;
  logic [7:0] DIN = 8'h00;
  logic       fault = 1'b0;

  logic [7:0] ibus0, ibus1;
  logic [1:0] s0_w, s1_w, s2_w, sout_w, svalid_w, busy_w, done_w, err_w, mux_w;
  logic [2:0] sel0, sel1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic b;
    logic last;
    logic err;
  } ent_t;

  ent_t q0[$];
  ent_t q1[$];
  bit   mbusy[2] = '{1'b0, 1'b0};
  bit   merr[2]  = '{1'b0, 1'b0};
  int   nsamp[2] = '{0, 0};
  logic [7:0] cur_word = 8'h00;

  always #5 CLK = ~CLK;

  mux_8_1_scan_ctrl #(.MSB_FIRST(1'b0)) u_lsb (
    .CLK(CLK), .RST_N(RST_N), .LOAD(LOAD), .DIN(DIN), .HOLD(HOLD), .MUX_OUT(mux_w[0]),
    .I_BUS(ibus0), .S0(s0_w[0]), .S1(s1_w[0]), .S2(s2_w[0]), .SOUT(sout_w[0]),
    .SVALID(svalid_w[0]), .BUSY(busy_w[0]), .DONE(done_w[0]), .ERR(err_w[0])
  );

  mux_8_1_scan_ctrl #(.MSB_FIRST(1'b1)) u_msb (
    .CLK(CLK), .RST_N(RST_N), .LOAD(LOAD), .DIN(DIN), .HOLD(HOLD), .MUX_OUT(mux_w[1]),
    .I_BUS(ibus1), .S0(s0_w[1]), .S1(s1_w[1]), .S2(s2_w[1]), .SOUT(sout_w[1]),
    .SVALID(svalid_w[1]), .BUSY(busy_w[1]), .DONE(done_w[1]), .ERR(err_w[1])
  );

  // Mux environment: channel 4 optionally stuck at 0.
  assign sel0 = {s2_w[0], s1_w[0], s0_w[0]};
  assign sel1 = {s2_w[1], s1_w[1], s0_w[1]};
  assign mux_w[0] = (fault && sel0 == 3'd4) ? 1'b0 : ibus0[sel0];
  assign mux_w[1] = (fault && sel1 == 3'd4) ? 1'b0 : ibus1[sel1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model and monitor.
  ent_t       mon_e;
  logic [2:0] mon_sel;
  logic       mon_b;
  logic       mon_acc;
  int         mon_ch;

  always @(posedge CLK or negedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q0.delete();
      q1.delete();
      for (int k = 0; k < 2; k++) begin
        mbusy[k] = 1'b0;
        merr[k]  = 1'b0;
        nsamp[k] = 0;
      end
    end else if (CLK) begin
      if (LOAD && !mbusy[0]) begin
        cur_word = DIN;
        for (int k = 0; k < 2; k++) begin
          mon_acc = 1'b0;
          for (int i = 0; i < 8; i++) begin
            mon_ch  = (k == 1) ? 7 - i : i;
            mon_b   = (fault && mon_ch == 4) ? 1'b0 : DIN[mon_ch];
            mon_acc = mon_acc | (mon_b != DIN[mon_ch]);
            mon_e   = '{b: mon_b, last: (i == 7), err: mon_acc};
            if (k == 0) q0.push_back(mon_e);
            else        q1.push_back(mon_e);
          end
          mbusy[k] = 1'b1;
          merr[k]  = 1'b0;
          nsamp[k] = 0;
        end
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        mon_sel = (k == 0) ? sel0 : sel1;
        if (svalid_w[k]) begin
          if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            chk("unexpected_svalid", svalid_w[k], 1'b0);
          end else begin
            mon_e = (k == 0) ? q0.pop_front() : q1.pop_front();
            chk("sout", sout_w[k], mon_e.b);
            chk("done_on_sample", done_w[k], mon_e.last);
            chk("err_at_sample", err_w[k], mon_e.err);
            merr[k] = mon_e.err;
            nsamp[k]++;
            if (mon_e.last) begin
              mbusy[k] = 1'b0;
              chk("sel_restore", mon_sel, (k == 1) ? 7 : 0);
            end
          end
        end else begin
          chk("done_without_svalid", done_w[k], 1'b0);
        end
        chk("busy", busy_w[k], mbusy[k]);
        chk("err", err_w[k], merr[k]);
        if (mbusy[k]) begin
          chk("sel", mon_sel, (k == 1) ? 7 - nsamp[k] : nsamp[k]);
          chk("i_bus", (k == 0) ? ibus0 : ibus1, cur_word);
        end
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (busy_w != 2'b00 && t < 60) begin
      @(negedge CLK);
      t++;
    end
    chk("idle_wait", busy_w, 2'b00);
  endtask

  // ev_kind: 0 none, 1 HOLD for 3 cycles, 2 LOAD pulse mid-scan, 3 async reset.
  task automatic scan(input logic [7:0] d, input bit flt, input int hold_pct,
                      input int ev_at, input int ev_kind);
    int seen = 0;
    int t = 0;
    bit fired = 1'b0;
    wait_idle();
    fault = flt;
    DIN   = d;
    LOAD  = 1'b1;
    @(posedge CLK);
    #1 LOAD = 1'b0;
    while (t < 60) begin
      @(negedge CLK);
      t++;
      if (svalid_w[0]) seen++;
      if (busy_w == 2'b00) break;
      if (ev_kind != 0 && !fired && seen == ev_at) begin
        fired = 1'b1;
        if (ev_kind == 1) begin
          HOLD = 1'b1;
          repeat (3) begin
            @(negedge CLK);
            chk("hold_gap_svalid", svalid_w, 2'b00);
          end
          HOLD = 1'b0;
        end else if (ev_kind == 2) begin
          DIN  = 8'h00;
          LOAD = 1'b1;
          @(posedge CLK);
          #1 LOAD = 1'b0;
          DIN = d;
        end else begin
          #2 RST_N = 1'b0;
          #1 chk("async_reset_outputs",
                 {ibus0, ibus1, s0_w, s1_w, s2_w, sout_w, svalid_w, busy_w, done_w, err_w}, 32'd0);
          @(negedge CLK);
          chk("reset_held_outputs", {svalid_w, done_w, busy_w}, 6'd0);
          #2 RST_N = 1'b1;
          HOLD = 1'b0;
          return;
        end
      end else if (hold_pct > 0) begin
        HOLD = ($urandom_range(0, 99) < hold_pct);
      end
    end
    HOLD = 1'b0;
    chk("scan_finished", busy_w, 2'b00);
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    chk("reset_state",
        {ibus0, ibus1, s0_w, s1_w, s2_w, sout_w, svalid_w, busy_w, done_w, err_w}, 32'd0);
    RST_N = 1'b1;

    scan(8'hA5, 1'b0, 0, 0, 0);
    scan(8'h01, 1'b0, 0, 0, 0);
    scan(8'hFF, 1'b0, 0, 3, 1);
    scan(8'h10, 1'b0, 0, 0, 0);
    scan(8'h10, 1'b1, 0, 0, 0);
    // ERR must persist through idle cycles, with HOLD wiggling to no effect.
    repeat (3) begin
      @(negedge CLK);
      HOLD = ~HOLD;
    end
    HOLD = 1'b0;
    chk("err_sticky_idle", err_w, 2'b11);
    scan(8'h5A, 1'b0, 0, 0, 0);
    scan(8'hC3, 1'b0, 0, 3, 2);
    scan(8'hB6, 1'b0, 0, 4, 3);
    scan(8'h3C, 1'b0, 0, 0, 0);

    for (int n = 0; n < 20; n++) begin
      scan(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), 30, 0, 0);
    end

    wait_idle();
    repeat (2) @(negedge CLK);
    chk("queue0_drained", q0.size(), 0);
    chk("queue1_drained", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
